line_flush: RTL and testbench
=============================

LINE_FLUSH -- requirements
Module: line_flush

Interface
REQ-001 BW, default 8, data word width; SHALL be >= 8.
REQ-002 LGFLEN, default 8, log2 of buffer depth (depth 2**LGFLEN).
REQ-003 MAXLINE, default 80, forced-flush line length; SHALL satisfy 1 <= MAXLINE <= 2**LGFLEN.
REQ-004 IDLE_TIMEOUT, default 0, idle clocks before a partial line is flushed; 0 disables the timeout.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 i_clk  input  1  clock, all logic on its rising edge.
REQ-007 i_reset  input  1  synchronous active-high reset.
REQ-008 i_stb  input  1  one-cycle write strobe for i_data.
REQ-009 i_data  input  BW  incoming word.
REQ-010 i_flush  input  1  request to flush everything currently buffered.
REQ-011 o_stb  output  1  output word valid.
REQ-012 o_data  output  BW  output word (buffer head).
REQ-013 i_busy  input  1  downstream busy; a transfer occurs when o_stb && !i_busy.
REQ-014 o_fill  output  LGFLEN+1  current buffer occupancy.
REQ-015 o_sending  output  1  high while in SEND state.
REQ-016 o_overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-017 Terminator: a word whose data[7:0] is 8'h0A or 8'h0D.
REQ-018 Write: i_stb with buffer not full stores i_data; i_stb while full drops the word and pulses o_overflow on the next cycle.
REQ-019 A simultaneous write and read while full SHALL be accepted, with no overflow.
REQ-020 The block SHALL keep n_term (LGFLEN+1 bits), the count of terminators in the buffer: +1 on a terminator write, -1 on a terminator read, unchanged when both happen in the same cycle.
REQ-021 The FSM SHALL have two states, IDLE and SEND.
REQ-022 IDLE->SEND triggers, in priority order:
- n_term > 0: remaining = o_fill.
- o_fill >= MAXLINE: remaining = MAXLINE.
- i_flush && o_fill > 0: remaining = o_fill.
- timeout expired && o_fill > 0: remaining = o_fill.
REQ-023 In SEND, o_stb = buffer not empty; o_data = buffer head, held stable while i_busy.
REQ-024 Each transfer SHALL decrement remaining; SEND->IDLE on the transfer of a terminator or on the transfer where remaining == 1.
REQ-025 In IDLE, o_stb SHALL be 0.
REQ-026 Writes SHALL continue to be accepted during SEND.
REQ-027 Latency: a word written into an empty buffer is at the head (o_data) on the next cycle; o_stb may assert in the cycle after IDLE->SEND.
REQ-028 Idle counter:
- clears on every accepted write and while in SEND;
- otherwise counts, saturating at IDLE_TIMEOUT;
- the timeout is expired when the counter == IDLE_TIMEOUT != 0.
REQ-029 The buffer SHALL never be empty while in SEND with remaining > 0 (invariant).
REQ-030 o_fill SHALL equal writes minus reads since reset and never exceed 2**LGFLEN.
REQ-031 Pointers SHALL wrap modulo 2**LGFLEN.

Reset
REQ-032 On i_reset, the state SHALL go to IDLE and the buffer SHALL be emptied.
REQ-033 On i_reset, o_fill, n_term, remaining and the idle counter SHALL be 0, and o_stb, o_sending and o_overflow SHALL be 0 in the following cycle.
REQ-034 A reset during SEND SHALL discard the partial line; inputs in the reset cycle are ignored.

Structure
REQ-035 A shared package SHALL hold the terminator constants 8'h0A and 8'h0D and the IDLE/SEND state encodings.
REQ-036 Storage SHALL be the existing sfifo sub-module (BW, LGFLEN); the FSM, counters and overflow logic live in line_flush.

Verification
REQ-037 Write "AB"+8'h0A with i_busy=0 -> o_data sequence 8'h41, 8'h42, 8'h0A; then IDLE, o_fill=0.
REQ-038 Write 85 non-terminator bytes with MAXLINE=80 -> exactly 80 transferred, then IDLE with o_fill=5.
REQ-039 LGFLEN=4, 17 writes with no flush trigger (MAXLINE=16, output held busy) -> o_fill=16 and one o_overflow pulse.
REQ-040 IDLE_TIMEOUT=10, write 3 bytes and stay idle -> SEND entered 10 cycles after the last write and 3 bytes emitted.
REQ-041 "XY"+8'h0D+"Z" with i_busy high for 5 cycles per word -> o_data stable while busy, stop after 8'h0D, "Z" retained (o_fill=1).
REQ-042 Assert i_reset mid-SEND after 1 transfer -> next cycle o_stb=0, o_fill=0, IDLE; a later line is emitted correctly.

Source files
------------

// File: rtl/line_flush_pkg.sv
// ---------------------------------------------------------------------------
// line_flush_pkg
// Shared definitions for the line_flush block: the two line terminator
// bytes, the IDLE/SEND state encoding and a terminator test helper.
// ---------------------------------------------------------------------------
package line_flush_pkg;

    localparam logic [7:0] TERM_LF = 8'h0A;
    localparam logic [7:0] TERM_CR = 8'h0D;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } lf_state_e;

    // True when the low byte of a word ends a line.
    function automatic logic is_term(input logic [7:0] b);
        return (b == TERM_LF) || (b == TERM_CR);
    endfunction

endpackage

// File: rtl/line_flush_sfifo.sv
// ---------------------------------------------------------------------------
// sfifo
// Synchronous single-clock FIFO of depth 2**LGFLEN.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset (empties FIFO)
//   i_wr, i_data        write request and word
//   i_rd                read request (pops the head)
//   o_data              current head word (valid when !o_empty)
//   o_fill              occupancy, 0 .. 2**LGFLEN
//   o_empty, o_full     occupancy flags
// A write while full is accepted only if a read happens in the same cycle.
// ---------------------------------------------------------------------------
module sfifo #(
    parameter int BW     = 8,
    parameter int LGFLEN = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_empty,
    output logic              o_full
);

    localparam int DEPTH = 1 << LGFLEN;

    logic [BW-1:0]     mem [0:DEPTH-1];
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              do_wr_s, do_rd_s;
    logic              empty_s, full_s;

    assign empty_s = (fill_q == {(LGFLEN+1){1'b0}});
    assign full_s  = fill_q[LGFLEN];

    // Pointer and occupancy next-state; pointers wrap naturally at 2**LGFLEN.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        do_rd_s  = i_rd && !empty_s;
        do_wr_s  = i_wr && (!full_s || do_rd_s);
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= {LGFLEN{1'b0}};
            rd_ptr_q <= {LGFLEN{1'b0}};
            fill_q   <= {(LGFLEN+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (do_wr_s) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = mem[rd_ptr_q];
    assign o_fill  = fill_q;
    assign o_empty = empty_s;
    assign o_full  = full_s;

endmodule

// File: rtl/line_flush.sv
// ---------------------------------------------------------------------------
// line_flush
// Buffers incoming words and releases them a line at a time. A line is sent
// when a terminator (8'h0A / 8'h0D in the low byte) is buffered, when MAXLINE
// words are waiting, on an explicit flush, or after IDLE_TIMEOUT idle clocks.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_stb, i_data    input word strobe and data
//   i_flush          flush whatever is buffered
//   o_stb, o_data    output word valid / buffer head
//   i_busy           downstream stall; transfer when o_stb && !i_busy
//   o_fill           buffer occupancy
//   o_sending        high while a line is being sent
//   o_overflow       one-cycle pulse after a dropped write
// ---------------------------------------------------------------------------
module line_flush #(
    parameter int BW           = 8,
    parameter int LGFLEN       = 8,
    parameter int MAXLINE      = 80,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic [BW-1:0]     i_data,
    input  logic              i_flush,
    output logic              o_stb,
    output logic [BW-1:0]     o_data,
    input  logic              i_busy,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_sending,
    output logic              o_overflow
);

    import line_flush_pkg::*;

    localparam int              IW        = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0]   IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [LGFLEN:0] MAXLINE_W = (LGFLEN+1)'(MAXLINE);
    localparam logic [LGFLEN:0] ONE_W     = (LGFLEN+1)'(1);
    localparam logic [LGFLEN:0] ZERO_W    = (LGFLEN+1)'(0);

    lf_state_e       state_q, state_d;
    logic [LGFLEN:0] remaining_q, remaining_d;
    logic [LGFLEN:0] n_term_q, n_term_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            overflow_q, overflow_d;

    logic [BW-1:0]   fifo_data_s;
    logic [LGFLEN:0] fifo_fill_s;
    logic            fifo_empty_s, fifo_full_s;
    logic            rd_s, wr_ok_s, term_wr_s, term_rd_s, timeout_s, head_term_s;

    // A word leaves only while sending, when one is present and downstream is ready.
    assign rd_s        = (state_q == SEND) && !fifo_empty_s && !i_busy;
    // Mirrors the FIFO acceptance rule: full is fine if the head leaves this cycle.
    assign wr_ok_s     = i_stb && (!fifo_full_s || rd_s);
    assign head_term_s = is_term(fifo_data_s[7:0]);
    assign term_wr_s   = wr_ok_s && is_term(i_data[7:0]);
    assign term_rd_s   = rd_s && head_term_s;
    assign timeout_s   = (IDLE_TIMEOUT != 0) && (idle_cnt_q == IDLE_MAX);

    sfifo #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (i_stb),
        .i_data  (i_data),
        .i_rd    (rd_s),
        .o_data  (fifo_data_s),
        .o_fill  (fifo_fill_s),
        .o_empty (fifo_empty_s),
        .o_full  (fifo_full_s)
    );

    // Terminator count, idle counter and overflow pulse next-state.
    always_comb begin
        n_term_d   = n_term_q;
        idle_cnt_d = idle_cnt_q;
        overflow_d = i_stb && !wr_ok_s;
        case ({term_wr_s, term_rd_s})
            2'b10:   n_term_d = n_term_q + 1'b1;
            2'b01:   n_term_d = n_term_q - 1'b1;
            default: n_term_d = n_term_q;
        endcase
        if (wr_ok_s || (state_q == SEND)) begin
            idle_cnt_d = {IW{1'b0}};
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // Line FSM: choose what starts a line and how many words it may carry.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (n_term_q != ZERO_W) begin
                    state_d     = SEND;
                    remaining_d = fifo_fill_s;
                end else if (fifo_fill_s >= MAXLINE_W) begin
                    state_d     = SEND;
                    remaining_d = MAXLINE_W;
                end else if (i_flush && !fifo_empty_s) begin
                    state_d     = SEND;
                    remaining_d = fifo_fill_s;
                end else if (timeout_s && !fifo_empty_s) begin
                    state_d     = SEND;
                    remaining_d = fifo_fill_s;
                end else begin
                    state_d     = IDLE;
                    remaining_d = remaining_q;
                end
            end
            SEND: begin
                if (rd_s) begin
                    // The line ends at its terminator or when its word budget runs out.
                    if (head_term_s || (remaining_q == ONE_W)) begin
                        state_d     = IDLE;
                        remaining_d = ZERO_W;
                    end else begin
                        state_d     = SEND;
                        remaining_d = remaining_q - 1'b1;
                    end
                end else begin
                    state_d     = SEND;
                    remaining_d = remaining_q;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = ZERO_W;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            remaining_q <= ZERO_W;
            n_term_q    <= ZERO_W;
            idle_cnt_q  <= {IW{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            n_term_q    <= n_term_d;
            idle_cnt_q  <= idle_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_stb      = (state_q == SEND) && !fifo_empty_s;
    assign o_data     = fifo_data_s;
    assign o_fill     = fifo_fill_s;
    assign o_sending  = (state_q == SEND);
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_line_flush.sv
`timescale 1ns/1ps
// Bench for line_flush: three instances (default, small buffer, idle timeout)
// share one stimulus stream. Instance A is tracked every cycle by a queue
// based reference model; B and C get directed checks.
module tb_line_flush;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, stb, flush, busy;
    logic [7:0] data;

    logic       a_stb, a_sending, a_ovf;
    logic [7:0] a_data;
    logic [8:0] a_fill;
    logic       b_stb, b_sending, b_ovf;
    logic [7:0] b_data;
    logic [4:0] b_fill;
    logic       c_stb, c_sending, c_ovf;
    logic [7:0] c_data;
    logic [8:0] c_fill;

    line_flush #(.BW(8), .LGFLEN(8), .MAXLINE(80), .IDLE_TIMEOUT(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data), .i_flush(flush),
        .o_stb(a_stb), .o_data(a_data), .i_busy(busy), .o_fill(a_fill),
        .o_sending(a_sending), .o_overflow(a_ovf));

    line_flush #(.BW(8), .LGFLEN(4), .MAXLINE(16), .IDLE_TIMEOUT(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data), .i_flush(flush),
        .o_stb(b_stb), .o_data(b_data), .i_busy(busy), .o_fill(b_fill),
        .o_sending(b_sending), .o_overflow(b_ovf));

    line_flush #(.BW(8), .LGFLEN(8), .MAXLINE(80), .IDLE_TIMEOUT(10)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data), .i_flush(flush),
        .o_stb(c_stb), .o_data(c_data), .i_busy(busy), .o_fill(c_fill),
        .o_sending(c_sending), .o_overflow(c_ovf));

    int total = 0;
    int bad   = 0;

    // Reference model of instance A: buffered words, line in progress, budget.
    logic [7:0] mq[$];
    bit         m_send = 1'b0;
    int         m_rem  = 0;
    bit         m_ovf  = 1'b0;

    logic [7:0] got[$];
    int         c_xfers = 0;
    int         b_ovf_n = 0;

    function automatic bit is_t(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_update();
        bit xfer, acc;
        int nterm;
        if (rst) begin
            mq.delete();
            m_send = 1'b0;
            m_rem  = 0;
            m_ovf  = 1'b0;
            return;
        end
        xfer  = m_send && (mq.size() > 0) && !busy;
        acc   = stb && ((mq.size() < 256) || xfer);
        nterm = 0;
        foreach (mq[i]) if (is_t(mq[i])) nterm++;
        if (!m_send) begin
            if (nterm > 0) begin
                m_send = 1'b1; m_rem = mq.size();
            end else if (mq.size() >= 80) begin
                m_send = 1'b1; m_rem = 80;
            end else if (flush && mq.size() > 0) begin
                m_send = 1'b1; m_rem = mq.size();
            end
        end else if (xfer) begin
            if (is_t(mq[0]) || m_rem == 1) m_send = 1'b0;
            m_rem--;
        end
        if (xfer) void'(mq.pop_front());
        if (acc) mq.push_back(data);
        m_ovf = stb && !acc;
    endtask

    // Check instance A against the model, log transfers, then cross one edge.
    task automatic tick();
        chk("a_fill", a_fill, mq.size());
        chk("a_sending", a_sending, m_send);
        chk("a_overflow", a_ovf, m_ovf);
        chk("a_stb", a_stb, (m_send && mq.size() > 0));
        if (m_send && mq.size() > 0) chk("a_data", a_data, mq[0]);
        if (a_stb && !busy) got.push_back(a_data);
        if (c_stb && !busy) c_xfers++;
        if (b_ovf) b_ovf_n++;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        stb  = 1'b1;
        data = d;
        tick();
        stb  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] held;
        logic [7:0] d;

        rst = 1'b1; stb = 1'b0; flush = 1'b0; busy = 1'b0; data = 8'h00;
        @(posedge clk);
        #1;
        // Reset state of all three instances.
        chk("rst_a_fill", a_fill, 0);
        chk("rst_a_stb", a_stb, 0);
        chk("rst_a_sending", a_sending, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_fill", b_fill, 0);
        chk("rst_c_fill", c_fill, 0);
        chk("rst_c_sending", c_sending, 0);
        rst = 1'b0;

        // "AB\n" with no stall.
        got.delete();
        wr(8'h41); wr(8'h42); wr(8'h0A);
        idle(10);
        chk("t1_count", got.size(), 3);
        chk("t1_w0", got[0], 8'h41);
        chk("t1_w1", got[1], 8'h42);
        chk("t1_w2", got[2], 8'h0A);
        chk("t1_sending", a_sending, 0);
        chk("t1_fill", a_fill, 0);

        // 85 plain bytes: exactly MAXLINE leave, the rest stay.
        do_reset();
        got.delete();
        for (int i = 0; i < 85; i++) wr(8'h30 + 8'(i % 40));
        k = 0;
        while (a_sending && k < 300) begin tick(); k++; end
        chk("t2_bound", (k < 300), 1);
        idle(3);
        chk("t2_count", got.size(), 80);
        chk("t2_last", got[79], 8'h30 + 8'(79 % 40));
        chk("t2_fill", a_fill, 5);
        chk("t2_sending", a_sending, 0);

        // Small buffer held busy: 17 writes, one dropped.
        do_reset();
        b_ovf_n = 0;
        busy = 1'b1;
        for (int i = 0; i < 17; i++) wr(8'h61 + 8'(i));
        idle(3);
        chk("t3_b_fill", b_fill, 16);
        chk("t3_b_ovf_pulses", b_ovf_n, 1);
        chk("t3_b_stb", b_stb, 1);
        chk("t3_b_head", b_data, 8'h61);
        busy = 1'b0;

        // Idle timeout of 10 clocks on instance C.
        do_reset();
        c_xfers = 0;
        wr(8'h31); wr(8'h32); wr(8'h33);
        k = 0;
        while (!c_sending && k < 40) begin tick(); k++; end
        // Counter reaches 10 ten clocks after the write; SEND follows on that or the next edge.
        chk("t4_delay", ((k >= 10) && (k <= 11)), 1);
        idle(8);
        chk("t4_xfers", c_xfers, 3);
        chk("t4_c_fill", c_fill, 0);
        chk("t4_c_sending", c_sending, 0);

        // "XY\rZ" with five busy clocks per word.
        do_reset();
        got.delete();
        busy = 1'b1;
        wr(8'h58); wr(8'h59); wr(8'h0D); wr(8'h5A);
        for (int w = 0; w < 3; w++) begin
            held = a_data;
            for (int j = 0; j < 5; j++) begin
                tick();
                chk("t5_hold", a_data, held);
            end
            busy = 1'b0;
            tick();
            busy = 1'b1;
        end
        busy = 1'b0;
        idle(5);
        chk("t5_count", got.size(), 3);
        chk("t5_w0", got[0], 8'h58);
        chk("t5_w1", got[1], 8'h59);
        chk("t5_w2", got[2], 8'h0D);
        chk("t5_fill", a_fill, 1);
        chk("t5_sending", a_sending, 0);

        // Reset after one transfer; the strobe during reset must be ignored.
        do_reset();
        got.delete();
        wr(8'h50); wr(8'h51); wr(8'h52); wr(8'h0A);
        k = 0;
        while (got.size() < 1 && k < 20) begin tick(); k++; end
        chk("t6_first", got[0], 8'h50);
        rst = 1'b1; stb = 1'b1; data = 8'h0A;
        tick();
        rst = 1'b0; stb = 1'b0;
        chk("t6_stb", a_stb, 0);
        chk("t6_fill", a_fill, 0);
        chk("t6_sending", a_sending, 0);
        got.delete();
        wr(8'h6F); wr(8'h6B); wr(8'h0A);
        idle(10);
        chk("t6_count", got.size(), 3);
        chk("t6_w0", got[0], 8'h6F);
        chk("t6_w1", got[1], 8'h6B);
        chk("t6_w2", got[2], 8'h0A);
        chk("t6_fill_end", a_fill, 0);

        // Random traffic: a heavily stalled phase that overflows, then a lighter one.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                d = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
            end else begin
                d = 8'($urandom_range(0, 255));
                if (is_t(d)) d = 8'h20;
            end
            data  = d;
            busy  = (i < 1000) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        stb = 1'b0; busy = 1'b0; flush = 1'b1;
        k = 0;
        while ((a_fill != 0 || a_sending) && k < 2000) begin tick(); k++; end
        flush = 1'b0;
        idle(2);
        chk("t7_drained", a_fill, 0);
        chk("t7_idle", a_sending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
